iob_rr_arbiter: RTL and testbench
=================================

IOB_RR_ARBITER -- requirements
Module: iob_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N_MASTERS, default 2, meaning the number of IOb native masters sharing one slave (legal range 1..8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the IOb address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the IOb data width.
REQ-004 The block SHALL define the request and response widths as follows:
- REQ_W = 1+ADDR_W+DATA_W+DATA_W/8.
- Request field order from MSB: valid, address, wdata, wstrb.
- RESP_W = DATA_W+1.
- Response field order from MSB: rdata, ready.
REQ-005 Ports SHALL be, in order:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- m_req  in  N_MASTERS*REQ_W  master requests; master i occupies slice i.
- m_resp  out  N_MASTERS*RESP_W  master responses.
- s_req  out  REQ_W  shared slave request.
- s_resp  in  RESP_W  shared slave response.
- grant  out  N_MASTERS  one-hot owner of the slave; all zero when idle.
- busy  out  1  a transaction is in progress.

Function
REQ-006 The block SHALL implement a two-state FSM, IDLE and BUSY.
REQ-007 In IDLE, the FSM SHALL arbitrate as follows:
- Select one master among those with valid=1, using round-robin order starting at pointer ptr.
- Register the winner into grant.
- Go to BUSY in the same clock edge.
- With no valid masters, stay in IDLE with grant=0.
REQ-008 Arbitration latency SHALL be exactly 1 cycle: a master valid first sampled at edge t SHALL appear on s_req valid during cycle t+1.
REQ-009 In BUSY, s_req SHALL be the granted master's full request slice, passed through combinationally.
REQ-010 In IDLE, s_req SHALL be all zeros.
REQ-011 In BUSY, m_resp for the granted master SHALL equal s_resp combinationally.
REQ-012 Every non-granted master, and all masters in IDLE, SHALL see rdata=0 and ready=0.
REQ-013 In BUSY, when s_resp ready=1, the FSM SHALL do the following at the next edge:
- Return to IDLE.
- Clear grant.
- Set ptr = (winner+1) mod N_MASTERS.
REQ-014 The FSM SHALL NOT perform back-to-back arbitration: after a completion, the next s_req valid SHALL appear no earlier than 2 cycles later.
REQ-015 The granted master SHALL hold its request stable until ready.
REQ-016 If the granted master drops valid before ready (protocol violation), the block SHALL do the following:
- Remain in BUSY.
- Drive s_req valid=0.
- Wait for s_resp ready before returning to IDLE.
REQ-017 A slave ready asserted in the same cycle that s_req valid first rises SHALL be accepted as completion.
REQ-018 A new request arriving while BUSY SHALL wait without loss and be considered at the next IDLE cycle.
REQ-019 When ptr wraps from N_MASTERS-1, it SHALL go to 0.
REQ-020 With N_MASTERS=1, the block SHALL behave as a 1-cycle-latency registered pass-through with ptr held at 0.
REQ-021 The busy output SHALL be 1 exactly when the FSM is in BUSY.
REQ-022 A read SHALL be indicated by wstrb=0 and a write by wstrb≠0; the arbiter SHALL NOT treat them differently.

Reset
REQ-023 On rst=0, the block SHALL asynchronously set state=IDLE, grant=0, ptr=0 and busy=0; s_req and m_resp SHALL then be all zero.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction immediately; no response SHALL be forwarded after reset asserts.
REQ-025 After reset deasserts, the first arbitration SHALL occur on the first rising edge with rst=1.

Configuration
REQ-026 The feature macro SHALL be IOB_ARB_FIXED_PRIO_EN.
REQ-027 With IOB_ARB_FIXED_PRIO_EN defined:
- Arbitration SHALL be fixed priority, with the lowest index winning.
- ptr SHALL be absent, or tied to 0.
REQ-028 Without IOB_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-007 and REQ-013.

Verification
REQ-029 The bench SHALL cover a single master: with N=2, master0 reads addr 0x100 and the slave returns 0xDEADBEEF with ready 2 cycles after s_req valid. Required response:
- grant=01 one cycle after valid.
- m_resp0 rdata=0xDEADBEEF, ready=1.
- m_resp1 = 0.
REQ-030 The bench SHALL cover contention: both masters valid continuously from reset, slave ready 1 cycle after valid. Required response:
- grant sequence 01, 10, 01, 10.
- Each master gets exactly 2 of 4 transactions.
- With IOB_ARB_FIXED_PRIO_EN, all 4 go to master0.
REQ-031 The bench SHALL cover a zero-wait slave: the slave asserts ready in the first s_req valid cycle. Required response:
- busy high for exactly 1 cycle.
- ptr advances.
- Next grant no earlier than 2 cycles later.
REQ-032 The bench SHALL cover reset mid-operation: rst=0 while BUSY and before ready. Required response:
- grant=0, busy=0 and s_req=0 immediately (asynchronous).
- After release, ptr=0 and master0 wins first.
REQ-033 The bench SHALL cover wrap-around: with N=3, masters 2 then 0 valid with ptr=2. Required response:
- Master2 wins.
- ptr becomes 0.
- Master0 wins next.
REQ-034 The bench SHALL cover a write: master1 writes wdata 0x12345678 with wstrb 0xF to addr 0x40. Required response:
- s_req carries exactly those fields.
- Master0 sees ready=0 throughout.

Source files
------------

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter letting N_MASTERS IOb native masters share one slave.
// Define IOB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, ptr tied to 0).
module iob_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          grant,
    output logic                          busy
);
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     sel;
    logic                 any_vld;
    logic [N_MASTERS-1:0] vld;

    genvar i;
    generate
        for (i = 0; i < N_MASTERS; i++) begin : g_master
            assign vld[i] = m_req[i*REQ_W + REQ_W - 1];
            // Only the owner ever sees the slave response.
            assign m_resp[i*RESP_W +: RESP_W] = (busy && grant[i]) ? s_resp : '0;
        end
    endgenerate

    // First valid master at or after ptr, wrapping past the top index.
    always_comb begin
        any_vld = 1'b0;
        sel     = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!any_vld && vld[idx]) begin
                any_vld = 1'b1;
                sel     = IDX_W'(idx);
            end
        end
    end

`ifdef IOB_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDX_W-1:0] ptr_nxt;
    assign ptr_nxt = (win == IDX_W'(N_MASTERS - 1)) ? '0 : win + IDX_W'(1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            win   <= '0;
`ifndef IOB_ARB_FIXED_PRIO_EN
            ptr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        win   <= sel;
                        grant <= N_MASTERS'(1) << sel;
                    end
                end
                BUSY: begin
                    // Completion depends only on slave ready, even if the owner dropped valid.
                    if (s_resp[0]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        grant <= '0;
`ifndef IOB_ARB_FIXED_PRIO_EN
                        ptr   <= ptr_nxt;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                end
            endcase
        end
    end

    assign s_req = busy ? m_req[win*REQ_W +: REQ_W] : '0;

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Directed bench for iob_rr_arbiter: a 2-master instance plus a 3-master instance for wrap-around.
module tb_iob_rr_arbiter;
    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [2*REQ_W-1:0]    m_req;
    logic [2*RESP_W-1:0]   m_resp;
    logic [REQ_W-1:0]      s_req;
    logic [RESP_W-1:0]     s_resp;
    logic [1:0]            grant;
    logic                  busy;

    logic [3*REQ_W-1:0]    m_req3;
    logic [3*RESP_W-1:0]   m_resp3;
    logic [REQ_W-1:0]      s_req3;
    logic [RESP_W-1:0]     s_resp3;
    logic [2:0]            grant3;
    logic                  busy3;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    iob_rr_arbiter #(.N_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
        .s_req(s_req), .s_resp(s_resp), .grant(grant), .busy(busy)
    );

    iob_rr_arbiter #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32)) dut3 (
        .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3),
        .s_req(s_req3), .s_resp(s_resp3), .grant(grant3), .busy(busy3)
    );

    function automatic logic [REQ_W-1:0] mk(input logic v, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_run++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_run++; if (s_req !== '0) begin n_fail++; $display("FAIL reset_s_req: got %h want 0", s_req); end
        n_run++; if (m_resp !== '0) begin n_fail++; $display("FAIL reset_m_resp: got %h want 0", m_resp); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        m_req[0 +: REQ_W] = mk(1'b1, 32'h100, 32'h0, 4'h0);
        tick();
        n_run++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", grant); end
        n_run++; if (s_req !== mk(1'b1, 32'h100, 32'h0, 4'h0)) begin n_fail++; $display("FAIL single_s_req: got %h", s_req); end
        tick();
        tick();
        s_resp = {32'hDEADBEEF, 1'b1};
        #1;
        n_run++; if (m_resp[0 +: RESP_W] !== {32'hDEADBEEF, 1'b1}) begin n_fail++; $display("FAIL single_resp0: got %h want 1bd5b7ddf", m_resp[0 +: RESP_W]); end
        n_run++; if (m_resp[RESP_W +: RESP_W] !== '0) begin n_fail++; $display("FAIL single_resp1: got %h want 0", m_resp[RESP_W +: RESP_W]); end
        tick();
        m_req  = '0;
        s_resp = '0;
        n_run++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: grant %b busy %b want 00 0", grant, busy); end
    endtask

    task automatic test_contention();
        logic [1:0] exp [4];
        int cnt0 = 0;
        int cnt1 = 0;
`ifdef IOB_ARB_FIXED_PRIO_EN
        exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rst   = 1'b0;
        m_req = {mk(1'b1, 32'h200, 32'h0, 4'h0), mk(1'b1, 32'h100, 32'h0, 4'h0)};
        #1;
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            int w = 0;
            while (!busy && w < 8) begin tick(); w++; end
            n_run++; if (!busy) begin n_fail++; $display("FAIL cont_timeout: txn %0d busy %b want 1", t, busy); end
            n_run++; if (grant !== exp[t]) begin n_fail++; $display("FAIL cont_grant%0d: got %b want %b", t, grant, exp[t]); end
            if (grant == 2'b01) cnt0++;
            else if (grant == 2'b10) cnt1++;
            tick();
            s_resp = {32'h0, 1'b1};
            tick();
            s_resp = '0;
            if (t == 3) m_req = '0;
            n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_gap%0d: busy %b want 0", t, busy); end
        end
`ifdef IOB_ARB_FIXED_PRIO_EN
        n_run++; if (cnt0 != 4 || cnt1 != 0) begin n_fail++; $display("FAIL cont_share: m0 %0d m1 %0d want 4 0", cnt0, cnt1); end
`else
        n_run++; if (cnt0 != 2 || cnt1 != 2) begin n_fail++; $display("FAIL cont_share: m0 %0d m1 %0d want 2 2", cnt0, cnt1); end
`endif
    endtask

    task automatic test_zero_wait();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        m_req[0 +: REQ_W] = mk(1'b1, 32'h300, 32'h0, 4'h0);
        tick();
        n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zw_busy_on: got %b want 1", busy); end
        s_resp = {32'hCAFE0001, 1'b1};
        #1;
        n_run++; if (m_resp[0 +: RESP_W] !== {32'hCAFE0001, 1'b1}) begin n_fail++; $display("FAIL zw_resp0: got %h", m_resp[0 +: RESP_W]); end
        tick();
        s_resp = '0;
        m_req  = {mk(1'b1, 32'h204, 32'h0, 4'h0), mk(1'b1, 32'h304, 32'h0, 4'h0)};
        n_run++; if (busy !== 1'b0 || grant !== 2'b00) begin n_fail++; $display("FAIL zw_busy_off: busy %b grant %b want 0 00", busy, grant); end
        tick();
`ifdef IOB_ARB_FIXED_PRIO_EN
        n_run++; if (grant !== 2'b01) begin n_fail++; $display("FAIL zw_next_grant: got %b want 01", grant); end
`else
        n_run++; if (grant !== 2'b10) begin n_fail++; $display("FAIL zw_next_grant: got %b want 10", grant); end
`endif
        s_resp = {32'h0, 1'b1};
        tick();
        s_resp = '0;
        m_req  = '0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        m_req[0 +: REQ_W] = mk(1'b1, 32'h100, 32'h0, 4'h0);
        tick();
        s_resp = {32'h0, 1'b1};
        tick();
        s_resp = '0;
        m_req  = {mk(1'b1, 32'h208, 32'h0, 4'h0), {REQ_W{1'b0}}};
        tick();
        n_run++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rmid_pre_grant: got %b want 10", grant); end
        #2;
        rst    = 1'b0;
        s_resp = {32'h55AA55AA, 1'b1};
        #1;
        n_run++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async: grant %b busy %b want 00 0", grant, busy); end
        n_run++; if (s_req !== '0) begin n_fail++; $display("FAIL rmid_s_req: got %h want 0", s_req); end
        n_run++; if (m_resp !== '0) begin n_fail++; $display("FAIL rmid_m_resp: got %h want 0", m_resp); end
        m_req  = {mk(1'b1, 32'h208, 32'h0, 4'h0), mk(1'b1, 32'h108, 32'h0, 4'h0)};
        s_resp = '0;
        #1;
        rst = 1'b1;
        tick();
        n_run++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rmid_first_win: got %b want 01", grant); end
        s_resp = {32'h0, 1'b1};
        tick();
        s_resp = '0;
        m_req  = '0;
    endtask

    task automatic test_write();
        m_req = {mk(1'b1, 32'h40, 32'h12345678, 4'hF), {REQ_W{1'b0}}};
        tick();
        n_run++; if (grant !== 2'b10) begin n_fail++; $display("FAIL wr_grant: got %b want 10", grant); end
        n_run++; if (s_req !== mk(1'b1, 32'h40, 32'h12345678, 4'hF)) begin n_fail++; $display("FAIL wr_s_req: got %h", s_req); end
        n_run++; if (m_resp[0] !== 1'b0) begin n_fail++; $display("FAIL wr_m0_ready_wait: got %b want 0", m_resp[0]); end
        tick();
        s_resp = {32'h0, 1'b1};
        #1;
        n_run++; if (m_resp[0] !== 1'b0) begin n_fail++; $display("FAIL wr_m0_ready_done: got %b want 0", m_resp[0]); end
        n_run++; if (m_resp[RESP_W] !== 1'b1) begin n_fail++; $display("FAIL wr_m1_ready: got %b want 1", m_resp[RESP_W]); end
        tick();
        s_resp = '0;
        m_req  = '0;
    endtask

    task automatic test_wrap();
        m_req3[REQ_W +: REQ_W] = mk(1'b1, 32'h500, 32'h0, 4'h0);
        tick();
        n_run++; if (grant3 !== 3'b010) begin n_fail++; $display("FAIL wrap_setup: got %b want 010", grant3); end
        s_resp3 = {32'h0, 1'b1};
        tick();
        s_resp3 = '0;
        m_req3  = {mk(1'b1, 32'h520, 32'h0, 4'h0), {REQ_W{1'b0}}, mk(1'b1, 32'h600, 32'h0, 4'h0)};
        tick();
`ifdef IOB_ARB_FIXED_PRIO_EN
        n_run++; if (grant3 !== 3'b001) begin n_fail++; $display("FAIL wrap_first: got %b want 001", grant3); end
`else
        n_run++; if (grant3 !== 3'b100) begin n_fail++; $display("FAIL wrap_first: got %b want 100", grant3); end
`endif
        s_resp3 = {32'h0, 1'b1};
        tick();
        s_resp3 = '0;
        n_run++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL wrap_gap: busy %b want 0", busy3); end
        tick();
        n_run++; if (grant3 !== 3'b001) begin n_fail++; $display("FAIL wrap_second: got %b want 001", grant3); end
        s_resp3 = {32'h0, 1'b1};
        tick();
        s_resp3 = '0;
        m_req3  = '0;
    endtask

    initial begin
        rst     = 1'b1;
        m_req   = '0;
        s_resp  = '0;
        m_req3  = '0;
        s_resp3 = '0;
        #2;
        rst = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_zero_wait();
        test_reset_mid();
        test_write();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
